node_eject_sam: RTL and testbench

- Ejection-side counterpart of the request-node address-map stamping at NoC injection.
- Sits between a router's local output port and the attached target device.
- Checks that each arriving flit's tgt_id addresses this node, buffers accepted flits in per-VC FIFOs, and presents them to the device over a valid/ready handshake.
- Returns link credits to the router, and drops and counts misrouted or overflowing flits.

---
 rtl/rvh_noc_pkg.sv | 43 ++++
 rtl/node_eject_vc_fifo.sv | 62 ++++++
 rtl/rvh_rr_arb_onehot.sv | 66 ++++++
 rtl/node_eject_sam.sv | 157 +++++++++++++++
 tb/tb_node_eject_sam.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvh_noc_pkg.sv
// Shared NoC types and constants for the ejection node.
// Holds the node-id struct, the 256-bit flit layout, VC sizing and a helper
// that decides whether a target id addresses the local node.
package rvh_noc_pkg;

  localparam int unsigned VC_NUM    = 2;
  localparam int unsigned VC_DEPTH  = 4;
  localparam int unsigned ERR_CNT_W = 8;

  localparam int unsigned VC_ID_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PEND_W  = $clog2(VC_DEPTH + 1);

  localparam int unsigned NodeID_X_Width    = 4;
  localparam int unsigned NodeID_Y_Width    = 4;
  localparam int unsigned NodeID_Port_Width = 2;
  localparam int unsigned NodeID_Dev_Width  = 2;

  typedef struct packed {
    logic [NodeID_X_Width-1:0]    x_position;
    logic [NodeID_Y_Width-1:0]    y_position;
    logic [NodeID_Port_Width-1:0] device_port;
    logic [NodeID_Dev_Width-1:0]  device_id;
  } node_id_t;

  localparam int unsigned FlitW    = 256;
  localparam int unsigned NodeIdW  = $bits(node_id_t);
  localparam int unsigned PayloadW = FlitW - 2 * NodeIdW;

  typedef struct packed {
    logic [PayloadW-1:0] payload;
    node_id_t            src_id;
    node_id_t            tgt_id;
  } flit_payload_t;

  // Only device 0 on port 0 of this router position is a valid ejection target.
  function automatic logic is_local(input node_id_t                  tgt,
                                    input logic [NodeID_X_Width-1:0] x,
                                    input logic [NodeID_Y_Width-1:0] y);
    return (tgt.x_position == x) && (tgt.y_position == y) &&
           (tgt.device_port == '0) && (tgt.device_id == '0);
  endfunction

endpackage

// File: rtl/node_eject_vc_fifo.sv
// Single-VC flit FIFO for the ejection node.
// Ports: wr_en_i/wr_data_i push; rd_en_i pops the head shown on rd_data_o;
// full_o, empty_o and count_o report occupancy. Push and pop in one cycle
// are legal even when full. Callers never pop when empty.
module node_eject_vc_fifo
  import rvh_noc_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en_i,
  input  flit_payload_t wr_data_i,
  input  logic          rd_en_i,
  output flit_payload_t rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  flit_payload_t   mem_q [Depth];
  flit_payload_t   mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en_i) begin
      mem_d[wptr_q] = wr_data_i;
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (rd_en_i) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(wr_en_i) - CntW'(rd_en_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;

endmodule

// File: rtl/rvh_rr_arb_onehot.sv
// One-hot round-robin arbiter shared across the NoC.
// Ports: req_i request vector; hold_i keeps the current grant for the next
// cycle; adv_i moves the priority pointer past the current grant;
// gnt_o one-hot grant; gnt_idx_o binary index of the grant (0 when idle).
module rvh_rr_arb_onehot #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          hold_q, hold_d;
  logic [N-1:0]  hold_gnt_q, hold_gnt_d;
  logic [N-1:0]  rr_gnt;
  logic          found;

  always_comb begin
    rr_gnt = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % int'(N);
      if (!found && req_i[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
    end

    // A held grant wins over the rotating choice so the winner cannot change
    // while its consumer is stalled.
    gnt_o = hold_q ? hold_gnt_q : rr_gnt;

    gnt_idx_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_o[i]) gnt_idx_o = IW'(i);
    end

    ptr_d = ptr_q;
    if (adv_i && |gnt_o) begin
      ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end

    hold_d     = hold_i && |gnt_o;
    hold_gnt_d = gnt_o;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_gnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      hold_gnt_q <= hold_gnt_d;
    end
  end

endmodule

// File: rtl/node_eject_sam.sv
// Ejection-side address-map check between a router local port and a device.
// Inputs: flit_v_i/flit_i/flit_vc_id_i from the router, node_id_x_i/_y_i
// this node's position, rx_rdy_i device ready.
// Outputs: rx_v_o/rx_flit_o/rx_vc_id_o/rx_src_x_o/rx_src_y_o to the device,
// lcrd_v_o/lcrd_vc_id_o registered credit return, misroute_cnt_o saturating
// drop counter, ovf_err_o sticky overflow flag.
module node_eject_sam
  import rvh_noc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flit_v_i,
  input  flit_payload_t             flit_i,
  input  logic [VC_ID_W-1:0]        flit_vc_id_i,
  input  logic [NodeID_X_Width-1:0] node_id_x_i,
  input  logic [NodeID_Y_Width-1:0] node_id_y_i,
  output logic                      lcrd_v_o,
  output logic [VC_ID_W-1:0]        lcrd_vc_id_o,
  output logic                      rx_v_o,
  input  logic                      rx_rdy_i,
  output flit_payload_t             rx_flit_o,
  output logic [VC_ID_W-1:0]        rx_vc_id_o,
  output logic [NodeID_X_Width-1:0] rx_src_x_o,
  output logic [NodeID_Y_Width-1:0] rx_src_y_o,
  output logic [ERR_CNT_W-1:0]      misroute_cnt_o,
  output logic                      ovf_err_o
);

  localparam int unsigned CntW = $clog2(VC_DEPTH + 1);

  logic [VC_NUM-1:0] fifo_full, fifo_empty, fifo_wr, fifo_rd;
  flit_payload_t     fifo_head [VC_NUM];
  logic [CntW-1:0]   fifo_cnt  [VC_NUM];

  logic [VC_NUM-1:0]  out_gnt, cr_gnt, cr_req, mis_vc;
  logic [VC_ID_W-1:0] out_idx, cr_idx;
  logic               match, deq;

  logic [ERR_CNT_W-1:0] misroute_cnt_q, misroute_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [PEND_W-1:0]    pend_q [VC_NUM];
  logic [PEND_W-1:0]    pend_d [VC_NUM];
  logic                 lcrd_v_q, lcrd_v_d;
  logic [VC_ID_W-1:0]   lcrd_vc_q, lcrd_vc_d;

  for (genvar g = 0; g < int'(VC_NUM); g++) begin : g_vc
    node_eject_vc_fifo #(
      .Depth (VC_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (fifo_wr[g]),
      .wr_data_i (flit_i),
      .rd_en_i   (fifo_rd[g]),
      .rd_data_o (fifo_head[g]),
      .full_o    (fifo_full[g]),
      .empty_o   (fifo_empty[g]),
      .count_o   (fifo_cnt[g])
    );

    assign cr_req[g] = (pend_q[g] != '0);

    pend_le_depth: assert property (@(posedge clk) disable iff (!rstn)
      pend_q[g] <= PEND_W'(VC_DEPTH));
    occ_le_depth: assert property (@(posedge clk) disable iff (!rstn)
      fifo_cnt[g] <= CntW'(VC_DEPTH));
  end

  assign rx_v_o = |(~fifo_empty);
  assign deq    = rx_v_o && rx_rdy_i;
  assign match  = is_local(flit_i.tgt_id, node_id_x_i, node_id_y_i);

  rvh_rr_arb_onehot #(
    .N (VC_NUM)
  ) u_out_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (~fifo_empty),
    .hold_i    (rx_v_o && !rx_rdy_i),
    .adv_i     (deq),
    .gnt_o     (out_gnt),
    .gnt_idx_o (out_idx)
  );

  // Credits are chosen from registered pending counts only; every non-zero
  // VC is served each time the grant rotates to it.
  rvh_rr_arb_onehot #(
    .N (VC_NUM)
  ) u_cr_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (cr_req),
    .hold_i    (1'b0),
    .adv_i     (1'b1),
    .gnt_o     (cr_gnt),
    .gnt_idx_o (cr_idx)
  );

  always_comb begin
    fifo_rd        = out_gnt & {VC_NUM{deq}};
    fifo_wr        = '0;
    mis_vc         = '0;
    ovf_d          = ovf_q;
    misroute_cnt_d = misroute_cnt_q;

    for (int v = 0; v < int'(VC_NUM); v++) begin
      if (flit_v_i && (flit_vc_id_i == VC_ID_W'(v))) begin
        if (!match) begin
          mis_vc[v] = 1'b1;
        end else if (!fifo_full[v] || fifo_rd[v]) begin
          fifo_wr[v] = 1'b1;
        end else begin
          // Sender overran its credits; the flit is lost and earns no credit.
          ovf_d = 1'b1;
        end
      end
    end

    if (flit_v_i && !match && (misroute_cnt_q != '1)) begin
      misroute_cnt_d = misroute_cnt_q + 1'b1;
    end

    for (int v = 0; v < int'(VC_NUM); v++) begin
      pend_d[v] = pend_q[v] + PEND_W'(fifo_rd[v]) + PEND_W'(mis_vc[v])
                - PEND_W'(cr_gnt[v]);
    end

    lcrd_v_d  = |cr_gnt;
    lcrd_vc_d = cr_idx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misroute_cnt_q <= '0;
      ovf_q          <= 1'b0;
      lcrd_v_q       <= 1'b0;
      lcrd_vc_q      <= '0;
      for (int v = 0; v < int'(VC_NUM); v++) pend_q[v] <= '0;
    end else begin
      misroute_cnt_q <= misroute_cnt_d;
      ovf_q          <= ovf_d;
      lcrd_v_q       <= lcrd_v_d;
      lcrd_vc_q      <= lcrd_vc_d;
      for (int v = 0; v < int'(VC_NUM); v++) pend_q[v] <= pend_d[v];
    end
  end

  assign rx_flit_o      = fifo_head[out_idx];
  assign rx_vc_id_o     = out_idx;
  assign rx_src_x_o     = rx_flit_o.src_id.x_position;
  assign rx_src_y_o     = rx_flit_o.src_id.y_position;
  assign lcrd_v_o       = lcrd_v_q;
  assign lcrd_vc_id_o   = lcrd_vc_q;
  assign misroute_cnt_o = misroute_cnt_q;
  assign ovf_err_o      = ovf_q;

endmodule

// File: tb/tb_node_eject_sam.sv
// Scoreboard bench for node_eject_sam: directed stimulus pushes expected
// device-side flits and credits; a negedge monitor pops and compares.
module tb_node_eject_sam;
  import rvh_noc_pkg::*;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      flit_v_i = 1'b0;
  flit_payload_t             flit_i = '0;
  logic [VC_ID_W-1:0]        flit_vc_id_i = '0;
  logic [NodeID_X_Width-1:0] node_id_x_i = 4'd1;
  logic [NodeID_Y_Width-1:0] node_id_y_i = 4'd0;
  logic                      lcrd_v_o;
  logic [VC_ID_W-1:0]        lcrd_vc_id_o;
  logic                      rx_v_o;
  logic                      rx_rdy_i = 1'b0;
  flit_payload_t             rx_flit_o;
  logic [VC_ID_W-1:0]        rx_vc_id_o;
  logic [NodeID_X_Width-1:0] rx_src_x_o;
  logic [NodeID_Y_Width-1:0] rx_src_y_o;
  logic [ERR_CNT_W-1:0]      misroute_cnt_o;
  logic                      ovf_err_o;

  node_eject_sam dut (
    .clk            (clk),
    .rstn           (rstn),
    .flit_v_i       (flit_v_i),
    .flit_i         (flit_i),
    .flit_vc_id_i   (flit_vc_id_i),
    .node_id_x_i    (node_id_x_i),
    .node_id_y_i    (node_id_y_i),
    .lcrd_v_o       (lcrd_v_o),
    .lcrd_vc_id_o   (lcrd_vc_id_o),
    .rx_v_o         (rx_v_o),
    .rx_rdy_i       (rx_rdy_i),
    .rx_flit_o      (rx_flit_o),
    .rx_vc_id_o     (rx_vc_id_o),
    .rx_src_x_o     (rx_src_x_o),
    .rx_src_y_o     (rx_src_y_o),
    .misroute_cnt_o (misroute_cnt_o),
    .ovf_err_o      (ovf_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VC_ID_W-1:0] vc;
    flit_payload_t      flit;
  } rx_exp_t;

  rx_exp_t            rx_q [$];
  logic [VC_ID_W-1:0] cr_q [$];
  int total = 0;
  int bad   = 0;
  int cr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_flit(input string name, input flit_payload_t act, input flit_payload_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic flit_payload_t mk(input int tx, input int ty, input int port, input int dev,
                                       input int sx, input int sy, input int tag);
    flit_payload_t f;
    f = '0;
    f.tgt_id.x_position  = NodeID_X_Width'(tx);
    f.tgt_id.y_position  = NodeID_Y_Width'(ty);
    f.tgt_id.device_port = NodeID_Port_Width'(port);
    f.tgt_id.device_id   = NodeID_Dev_Width'(dev);
    f.src_id.x_position  = NodeID_X_Width'(sx);
    f.src_id.y_position  = NodeID_Y_Width'(sy);
    f.payload[15:0]      = 16'(tag);
    return f;
  endfunction

  // Monitor: the presented head must match the scoreboard front; a handshake
  // pops it and earns one expected credit on the same VC.
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_v_o) begin
        if (rx_q.size() == 0) begin
          check("rx_spurious", 32'(rx_v_o), 32'd0);
        end else begin
          check_flit("rx_flit", rx_flit_o, rx_q[0].flit);
          check("rx_vc", 32'(rx_vc_id_o), 32'(rx_q[0].vc));
          check("rx_src_x", 32'(rx_src_x_o), 32'(rx_q[0].flit.src_id.x_position));
          check("rx_src_y", 32'(rx_src_y_o), 32'(rx_q[0].flit.src_id.y_position));
          if (rx_rdy_i) begin
            cr_q.push_back(rx_q[0].vc);
            void'(rx_q.pop_front());
          end
        end
      end
      if (lcrd_v_o) begin
        cr_seen++;
        if (cr_q.size() == 0) begin
          check("lcrd_spurious", 32'(lcrd_v_o), 32'd0);
        end else begin
          check("lcrd_vc", 32'(lcrd_vc_id_o), 32'(cr_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input flit_payload_t f, input int vc);
    flit_v_i     = 1'b1;
    flit_i       = f;
    flit_vc_id_i = VC_ID_W'(vc);
    cyc();
    flit_v_i = 1'b0;
  endtask

  task automatic push_rx(input flit_payload_t f, input int vc);
    rx_exp_t e;
    e.vc   = VC_ID_W'(vc);
    e.flit = f;
    rx_q.push_back(e);
  endtask

  // Bounded drain, then a few idle cycles so stray outputs reach the monitor.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() == 0 && cr_q.size() == 0) break;
      cyc();
    end
    repeat (5) cyc();
    check(name, 32'(rx_q.size() + cr_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    flit_payload_t f [6];
    int run;
    int cr0;

    repeat (3) cyc();
    check("rst_rx_v", 32'(rx_v_o), 32'd0);
    check("rst_rx_vc", 32'(rx_vc_id_o), 32'd0);
    check("rst_lcrd_v", 32'(lcrd_v_o), 32'd0);
    check("rst_lcrd_vc", 32'(lcrd_vc_id_o), 32'd0);
    check("rst_mis", 32'(misroute_cnt_o), 32'd0);
    check("rst_ovf", 32'(ovf_err_o), 32'd0);
    rstn = 1'b1;
    cyc();

    // Single matching flit, node (1,0), src (2,3).
    rx_rdy_i = 1'b1;
    f[0] = mk(1, 0, 0, 0, 2, 3, 16'h0001);
    push_rx(f[0], 0);
    check("t1_no_bypass", 32'(rx_v_o), 32'd0);
    send(f[0], 0);
    check("t1_rx_v", 32'(rx_v_o), 32'd1);
    check("t1_src_x", 32'(rx_src_x_o), 32'd2);
    check("t1_src_y", 32'(rx_src_y_o), 32'd3);
    cyc();
    cyc();
    check("t1_lcrd_v", 32'(lcrd_v_o), 32'd1);
    check("t1_lcrd_vc", 32'(lcrd_vc_id_o), 32'd0);
    wait_idle("t1_drain");

    // Misrouted flit (tgt x=3) on VC1.
    cr_q.push_back(1'b1);
    send(mk(3, 0, 0, 0, 2, 3, 16'h0002), 1);
    check("t2_rx_v", 32'(rx_v_o), 32'd0);
    check("t2_mis", 32'(misroute_cnt_o), 32'd1);
    wait_idle("t2_drain");

    // Stall, 2 flits to VC0 then 4 to VC1, then release.
    rx_rdy_i = 1'b0;
    for (int i = 0; i < 6; i++) f[i] = mk(1, 0, 0, 0, i, 5, 16'h0100 + i);
    push_rx(f[0], 0);
    push_rx(f[2], 1);
    push_rx(f[1], 0);
    push_rx(f[3], 1);
    push_rx(f[4], 1);
    push_rx(f[5], 1);
    send(f[0], 0);
    send(f[1], 0);
    for (int i = 2; i < 6; i++) send(f[i], 1);
    cyc();
    check("t3_stall_vc", 32'(rx_vc_id_o), 32'd0);
    check_flit("t3_stall_head", rx_flit_o, f[0]);
    cr0 = cr_seen;
    rx_rdy_i = 1'b1;
    wait_idle("t3_drain");
    check("t3_credits", 32'(cr_seen - cr0), 32'd6);

    // Overflow on VC0.
    rx_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f[i] = mk(1, 0, 0, 0, 7, i, 16'h0200 + i);
      push_rx(f[i], 0);
      send(f[i], 0);
    end
    check("t4_no_ovf", 32'(ovf_err_o), 32'd0);
    send(mk(1, 0, 0, 0, 7, 9, 16'h02ff), 0);
    check("t4_ovf", 32'(ovf_err_o), 32'd1);
    repeat (3) cyc();
    check("t4_ovf_hold", 32'(ovf_err_o), 32'd1);
    cr0 = cr_seen;
    rx_rdy_i = 1'b1;
    wait_idle("t4_drain");
    check("t4_credits", 32'(cr_seen - cr0), 32'd4);
    check("t4_ovf_sticky", 32'(ovf_err_o), 32'd1);

    // Dequeue and misroute on VC0 in the same cycle.
    rx_rdy_i = 1'b0;
    f[0] = mk(1, 0, 0, 0, 4, 4, 16'h0300);
    push_rx(f[0], 0);
    send(f[0], 0);
    rx_rdy_i = 1'b1;
    cr_q.push_back(1'b0);
    send(mk(1, 1, 0, 0, 4, 4, 16'h0301), 0);
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (lcrd_v_o && lcrd_vc_id_o == 1'b0) run++;
      else if (run > 0) break;
      cyc();
    end
    check("t5_lcrd_run", 32'(run), 32'd2);
    check("t5_mis", 32'(misroute_cnt_o), 32'd2);
    wait_idle("t5_drain");

    // Asynchronous reset with 3 flits buffered.
    rx_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f[i] = mk(1, 0, 0, 0, 1, 1, 16'h0400 + i);
      push_rx(f[i], i % 2);
      send(f[i], i % 2);
    end
    check("t7_pre_rx_v", 32'(rx_v_o), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("t7_rx_v", 32'(rx_v_o), 32'd0);
    check("t7_rx_vc", 32'(rx_vc_id_o), 32'd0);
    check("t7_lcrd_v", 32'(lcrd_v_o), 32'd0);
    check("t7_lcrd_vc", 32'(lcrd_vc_id_o), 32'd0);
    check("t7_mis", 32'(misroute_cnt_o), 32'd0);
    check("t7_ovf", 32'(ovf_err_o), 32'd0);
    rx_q.delete();
    cr_q.delete();
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();

    // Misroute counter saturation.
    rx_rdy_i = 1'b1;
    for (int i = 0; i < 254; i++) begin
      cr_q.push_back(1'b1);
      send(mk(2, 0, 0, 0, 0, 0, i), 1);
    end
    check("t6_mis_254", 32'(misroute_cnt_o), 32'd254);
    for (int i = 0; i < 4; i++) begin
      cr_q.push_back(1'b1);
      send(mk(1, 0, 1, 0, 0, 0, i), 1);
    end
    check("t6_mis_sat", 32'(misroute_cnt_o), 32'd255);
    wait_idle("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
